serial_word_capture: RTL and testbench
======================================

// Module: serial_word_capture
// PURPOSE
//  Receive end of the serial word path. Deserialises an LSB-first bit stream into a
//  WIDTH-bit word, one bit per Shift_En cycle. The stream comes from the parallel-load
//  shift-right register (its Shift_Out drives our Shift_In).
//  Counts bits, presents the completed word with a valid/ack handshake, and flags bits
//  lost while a word is still unacknowledged.
// PARAMETERS
//  WIDTH  17  word length in bits (>=2); must match the sending register
// PORTS
//  Clk        in   1               system clock, rising edge
//  Reset      in   1               asynchronous, active-high; clears all state
//  Start      in   1               arm/restart capture; clears count, shift reg, Overrun
//  Shift_In   in   1               serial data bit, sampled when Shift_En=1
//  Shift_En   in   1               bit-valid qualifier, one bit per asserted cycle
//  Ack        in   1               consumer accepts Data_Out (honoured only when Data_Valid=1)
//  Data_Out   out  WIDTH           last completed word; held until next completion
//  Data_Valid out  1               completed word pending acknowledgement
//  Busy       out  1               1 while in COLLECT
//  Overrun    out  1               sticky: a Shift_En arrived in DONE and its bit was dropped
//  Bit_Count  out  $clog2(WIDTH+1) bits captured in the current word
// BEHAVIOUR
//  Reset (async, no clock edge needed):
//   - state=IDLE; shift reg, Data_Out, Bit_Count = 0
//   - Data_Valid, Busy, Overrun = 0
//  FSM states: IDLE, COLLECT, DONE. All outputs are registered or decoded from state.
//  IDLE:
//   - Shift_En is ignored
//   - Start -> COLLECT; next edge sets Bit_Count=0, shift reg=0, Overrun=0
//  COLLECT, on Shift_En:
//   - shift right: sreg <= {Shift_In, sreg[WIDTH-1:1]}; Bit_Count++
//  Completion (COLLECT, Shift_En with Bit_Count==WIDTH-1):
//   - same edge: Data_Out <= {Shift_In, sreg[WIDTH-1:1]}; Data_Valid <= 1;
//     Bit_Count <= WIDTH; state -> DONE
//   - latency: Data_Valid high in the cycle after the WIDTH-th Shift_En
//   - the first bit received lands in Data_Out[0]
//  Start in COLLECT:
//   - restart; partial word discarded; Shift_En in that cycle is ignored
//  DONE:
//   - Data_Out held and Data_Valid=1 until Ack
//   - Ack -> Data_Valid 0 next cycle, state -> IDLE; Data_Out keeps its value
//   - Shift_En without Ack -> Overrun <= 1, bit dropped, Data_Out unchanged
//   - Ack+Start same cycle -> straight to COLLECT (count/sreg cleared, Data_Valid 0)
//   - Start without Ack -> ignored
//   - Ack+Shift_En same cycle -> bit dropped, no Overrun
//  Ack while Data_Valid=0: no effect.
//  Overrun clears only on Reset or an accepted Start.
//  Busy = (state==COLLECT). Bit_Count never exceeds WIDTH and does not wrap.
// STRUCTURE
//  Package serial_capture_pkg:
//   - typedef enum logic [1:0] {IDLE, COLLECT, DONE} cap_state_t
//   - localparam DEFAULT_WORD_W = 17
//  Sub-module sipo_shift_reg (WIDTH): shift-right with clear and enable, parallel out.
//  FSM, counter and handshake stay in this module.
// TESTING
//  1 Start; send 17'h12345 LSB first on 17 consecutive Shift_En
//    -> Data_Valid=1 next cycle, Data_Out=17'h12345, Busy=0, Bit_Count=17
//  2 Hold Ack=0 for 10 cycles -> Data_Valid stays 1; pulse Ack
//    -> Data_Valid=0 next cycle, FSM in IDLE, Data_Out still 17'h12345
//  3 Shift_En on every 3rd cycle, word 17'h0AAAA
//    -> Data_Out=17'h0AAAA; Bit_Count steps only on Shift_En cycles
//  4 In DONE, pulse Shift_En twice, no Ack -> Overrun=1, Data_Out unchanged;
//    Ack+Start together -> Overrun=0, Busy=1, Bit_Count=0
//  5 Start, 8 bits of 0, Start again, 17 bits of 1
//    -> Data_Out=17'h1FFFF, no stale zeros
//  6 Assert Reset between clock edges at bit 9
//    -> all outputs 0 immediately; Shift_En afterwards ignored until Start

Source files
------------

// File: rtl/serial_capture_pkg.sv
// Shared types and constants for the serial word capture path.
package serial_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } cap_state_t;

  localparam int DEFAULT_WORD_W = 17;

endpackage

// File: rtl/serial_word_capture_sipo.sv
// Serial-in parallel-out shift-right register with clear and enable.
// shifted_word is the value the register takes on an enabled shift, so a
// completing word can be captured on the same edge as its last bit.
module sipo_shift_reg #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] shifted_word
);

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;

  assign shifted_word = {din, sreg_q[WIDTH-1:1]};

  always_comb begin
    sreg_d = sreg_q;
    if (clr) begin
      sreg_d = '0;
    end else if (en) begin
      sreg_d = shifted_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/serial_word_capture.sv
// Deserialises an LSB-first bit stream into WIDTH-bit words with a valid/ack
// handshake; bits arriving while a word is unacknowledged set a sticky Overrun.
module serial_word_capture
  import serial_capture_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_W
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Shift_In,
  input  logic                       Shift_En,
  input  logic                       Ack,
  output logic [WIDTH-1:0]           Data_Out,
  output logic                       Data_Valid,
  output logic                       Busy,
  output logic                       Overrun,
  output logic [$clog2(WIDTH+1)-1:0] Bit_Count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL     = CW'(WIDTH);

  cap_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;
  logic             sreg_clr, sreg_en;
  logic [WIDTH-1:0] shifted_word;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sreg (
    .clk         (Clk),
    .rst         (Reset),
    .clr         (sreg_clr),
    .en          (sreg_en),
    .din         (Shift_In),
    .shifted_word(shifted_word)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    sreg_clr  = 1'b0;
    sreg_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = COLLECT;
          count_d   = '0;
          overrun_d = 1'b0;
          sreg_clr  = 1'b1;
        end
      end
      COLLECT: begin
        // A restart takes priority over any bit offered in the same cycle.
        if (Start) begin
          count_d   = '0;
          overrun_d = 1'b0;
          sreg_clr  = 1'b1;
        end else if (Shift_En) begin
          sreg_en = 1'b1;
          if (count_q == LAST_BIT) begin
            count_d = FULL;
            data_d  = shifted_word;
            state_d = DONE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (Ack) begin
          if (Start) begin
            state_d   = COLLECT;
            count_d   = '0;
            overrun_d = 1'b0;
            sreg_clr  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (Shift_En) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign Data_Out   = data_q;
  assign Data_Valid = (state_q == DONE);
  assign Busy       = (state_q == COLLECT);
  assign Overrun    = overrun_q;
  assign Bit_Count  = count_q;

endmodule

// File: tb/tb_serial_word_capture.sv
// Scoreboard bench for serial_word_capture: directed scenarios then random
// traffic, checked against a bit-list reference model of the capture rules.
module tb_serial_word_capture;

  localparam int W  = 17;
  localparam int CW = $clog2(W + 1);
  localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_DONE = 2;

  logic          Clk = 1'b0;
  logic          Reset, Start, Shift_In, Shift_En, Ack;
  logic [W-1:0]  Data_Out;
  logic          Data_Valid, Busy, Overrun;
  logic [CW-1:0] Bit_Count;

  int checks = 0;
  int failures = 0;

  // Reference model: received bits kept as a plain list, words assembled on completion.
  int           phase;
  logic         bits[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_word;
  int           m_count;
  logic         m_over;

  serial_word_capture #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Shift_In  (Shift_In),
    .Shift_En  (Shift_En),
    .Ack       (Ack),
    .Data_Out  (Data_Out),
    .Data_Valid(Data_Valid),
    .Busy      (Busy),
    .Overrun   (Overrun),
    .Bit_Count (Bit_Count)
  );

  always #5 Clk = ~Clk;

  task automatic compare(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    phase   = PH_IDLE;
    bits.delete();
    exp_q.delete();
    m_word  = '0;
    m_count = 0;
    m_over  = 1'b0;
  endtask

  // Apply the capture rules to one clock edge's inputs.
  task automatic modelStep(input logic st, input logic se, input logic si, input logic ack);
    logic [W-1:0] w;
    if (st && (phase != PH_DONE || ack)) begin
      phase   = PH_COLLECT;
      bits.delete();
      m_count = 0;
      m_over  = 1'b0;
    end else if (phase == PH_COLLECT && se) begin
      bits.push_back(si);
      m_count = bits.size();
      if (bits.size() == W) begin
        for (int i = 0; i < W; i++) w[i] = bits[i];
        m_word = w;
        exp_q.push_back(w);
        phase = PH_DONE;
      end
    end else if (phase == PH_DONE) begin
      if (ack) phase = PH_IDLE;
      else if (se) m_over = 1'b1;
    end
  endtask

  task automatic checkOutput();
    compare("busy", int'(Busy), int'(phase == PH_COLLECT));
    compare("data_valid", int'(Data_Valid), int'(phase == PH_DONE));
    compare("overrun", int'(Overrun), int'(m_over));
    compare("bit_count", int'(Bit_Count), m_count);
    compare("data_hold", int'(Data_Out), int'(m_word));
  endtask

  task automatic applyStimulus(input logic st, input logic se, input logic si, input logic ack);
    @(negedge Clk);
    Start = st; Shift_En = se; Shift_In = si; Ack = ack;
    modelStep(st, se, si, ack);
    @(posedge Clk);
    #1 checkOutput();
  endtask

  task automatic sendWord(input logic [W-1:0] word, input int gap);
    for (int i = 0; i < W; i++) begin
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, word[i], 1'b0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    compare({tag, "_data"}, int'(Data_Out), 0);
    compare({tag, "_valid"}, int'(Data_Valid), 0);
    compare({tag, "_busy"}, int'(Busy), 0);
    compare({tag, "_overrun"}, int'(Overrun), 0);
    compare({tag, "_count"}, int'(Bit_Count), 0);
  endtask

  // Monitor: each newly presented word must match the oldest expected one.
  initial begin
    logic prev_valid;
    logic [W-1:0] w;
    prev_valid = 1'b0;
    forever begin
      @(negedge Clk);
      if (Data_Valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL word_unexpected: got %0h expected none at %0t", Data_Out, $time);
        end else begin
          w = exp_q.pop_front();
          compare("word_out", int'(Data_Out), int'(w));
        end
      end
      prev_valid = Data_Valid;
    end
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Shift_In = 1'b0; Shift_En = 1'b0; Ack = 1'b0;
    modelReset();
    @(negedge Clk);
    @(negedge Clk);
    checkAllZero("reset");
    Reset = 1'b0;

    // Back-to-back word, then a long unacknowledged hold and an Ack.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendWord(17'h12345, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Sparse Shift_En, then overrun while pending and Ack+Start together.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendWord(17'h0AAAA, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    // Restart mid-word discards the partial zeros.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    sendWord(17'h1FFFF, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset partway through a word.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    Start = 1'b0; Shift_En = 1'b0; Shift_In = 1'b0; Ack = 1'b0;
    #2 Reset = 1'b1;
    #1 checkAllZero("async_reset");
    modelReset();
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0),
                    1'($urandom), ($urandom_range(0, 5) == 0));
    end

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    compare("words_outstanding", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
